alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WORD_WIDTH, default 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Parameter: OP_WIDTH, default 5, opcode width; op[4]=0 selects base ops, op[4]=1 selects mul/div ops.
REQ-003 Ports: clk  in  1  clock, all state on rising edge.
REQ-004 Ports: reset  in  1  asynchronous, active-high reset.
REQ-005 Ports: flush  in  1  synchronous kill of any in-flight or held operation.
REQ-006 Ports: in_valid  in  1; in_ready  out  1: input handshake, transfer when both are high.
REQ-007 Ports: a, b  in  WORD_WIDTH each: operands; op  in  OP_WIDTH: operation.
REQ-008 Ports: out_valid  out  1; out_ready  in  1: output handshake.
REQ-009 Ports: result  out  WORD_WIDTH; signal  out  alu_signal (zero, overflow, negative); error  out  1 (illegal op).

Function
REQ-010 Base ops, op[3:1]: 0 add (op[0]=0) / sub (op[0]=1); 1 sll; 2 slt signed; 3 sltu; 4 xor; 5 srl (op[0]=0) / sra (op[0]=1); 6 or; 7 and.
REQ-011 Base op with op[0]=1 and op[3:1] not in {0,5} SHALL complete normally with result 0, error=1.
REQ-012 Shift amount SHALL be b[$clog2(WORD_WIDTH)-1:0]; upper bits of b ignored.
REQ-013 Mul/div ops, op[2:0]: 0 MUL (low W), 1 MULH (ss), 2 MULHSU (a signed, b unsigned), 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU; op[3] ignored.
REQ-014 Divide by zero: quotient all ones, remainder = a, error=0.
REQ-015 Signed overflow (a = most negative, b = -1): DIV result = a, REM result = 0.
REQ-016 Mul/div SHALL be iterative radix-2 on operand magnitudes, one bit per cycle, sign fixed on the final cycle.
REQ-017 signal.zero = (result==0); signal.negative = result[W-1]; signal.overflow = carry-out of add, borrow of sub, 0 for all other ops.
REQ-018 FSM states IDLE, BUSY, DONE.
REQ-019 IDLE: accepted base op -> DONE; accepted mul/div op -> BUSY with counter loaded to WORD_WIDTH.
REQ-020 BUSY: counter decrements each cycle; at 0 -> DONE.
REQ-021 DONE: out_valid=1; result/signal/error stable until out_ready=1.
REQ-022 Latency: base op out_valid exactly 1 cycle after acceptance; mul/div exactly WORD_WIDTH+1 cycles after, for all operands, including divide by zero and overflow.
REQ-023 in_ready = !flush && (state==IDLE || (state==DONE && out_ready)); back-to-back base ops with out_ready held high give 1 result per cycle.
REQ-024 DONE with out_ready=1 and no new input -> IDLE, out_valid low next cycle.
REQ-025 flush=1 in any state -> IDLE next cycle, out_valid=0, operation discarded; flush wins over simultaneous in_valid.
REQ-026 Inputs a, b, op SHALL be captured at acceptance; later changes have no effect.

Reset
REQ-027 reset asserted: state=IDLE, out_valid=0, result=0, signal all 0, error=0, counter=0, immediately and without clk.
REQ-028 Reset mid-BUSY or mid-DONE SHALL discard the operation; first acceptance is allowed on the first clk edge after deassertion.

Structure
REQ-029 Package structs SHALL hold alu_signal, the alu_op enum (base and mul/div encodings) and the alu_mc state enum.
REQ-030 One sub-module SHALL be used: muldiv_iter, the iterative multiplier/divider with start/done, counter and sign fix-up.
REQ-031 Base-op datapath and the handshake/FSM SHALL remain in alu_mc.

Verification
REQ-032 ADD 0xFFFFFFFF+1, out_ready=1 -> next cycle result 0, zero=1, overflow=1, negative=0.
REQ-033 MULH 0x80000000*0x80000000 -> out_valid exactly 33 cycles after accept, result 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000; REM 0x80000000/-1 -> 0; each with latency 33.
REQ-035 out_ready=0 for 5 cycles in DONE -> outputs unchanged and in_ready=0 throughout; release -> single transfer.
REQ-036 flush 10 cycles into DIVU -> IDLE next cycle, no out_valid; flush with in_valid -> no acceptance; reset mid-BUSY -> all outputs 0 with no clk edge.
REQ-037 op=0b00011 (sll with op[0]=1) -> error=1, result 0; SRA 0x80000000 by b=0x21 -> shift by 1, result 0xC0000000.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared types for the multi-cycle ALU.
//   alu_signal  : result flags (zero, overflow, negative)
//   alu_op      : full 5-bit opcode encodings (base ops op[4]=0, mul/div op[4]=1)
//   alu_base_fn : base-op function field op[3:1]
//   alu_md_fn   : mul/div function field op[2:0]
//   alu_state   : handshake FSM states
package alu_mc_pkg;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic negative;
  } alu_signal;

  typedef enum logic [4:0] {
    OP_ADD    = 5'b00000,
    OP_SUB    = 5'b00001,
    OP_SLL    = 5'b00010,
    OP_SLT    = 5'b00100,
    OP_SLTU   = 5'b00110,
    OP_XOR    = 5'b01000,
    OP_SRL    = 5'b01010,
    OP_SRA    = 5'b01011,
    OP_OR     = 5'b01100,
    OP_AND    = 5'b01110,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } alu_op;

  typedef enum logic [2:0] {
    BASE_ADD  = 3'd0,
    BASE_SLL  = 3'd1,
    BASE_SLT  = 3'd2,
    BASE_SLTU = 3'd3,
    BASE_XOR  = 3'd4,
    BASE_SHR  = 3'd5,
    BASE_OR   = 3'd6,
    BASE_AND  = 3'd7
  } alu_base_fn;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } alu_md_fn;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state;

  // Only add/sub and srl/sra give op[0] a meaning; any other base op with
  // op[0] set is an illegal encoding.
  function automatic logic base_op_legal(input alu_base_fn fn, input logic variant);
    return !variant || (fn == BASE_ADD) || (fn == BASE_SHR);
  endfunction

endpackage

// File: rtl/alu_mc_muldiv_iter.sv
// muldiv_iter: iterative radix-2 multiplier/divider working on operand
// magnitudes, one bit per cycle, with the sign applied on the last step.
//   clk, reset   : clock, async active-high reset
//   flush        : abandon any operation in progress
//   start        : load operands a, b and function fn, begin iterating
//   fn           : alu_md_fn encoding (op[2:0])
//   done         : high during the final iteration cycle; result valid then
//   result       : signed/unsigned corrected product half, quotient or remainder
module muldiv_iter
  import alu_mc_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  start,
  input  logic [2:0]            fn,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] result
);

  localparam int W  = WORD_WIDTH;
  localparam int CW = $clog2(W) + 1;

  logic            busy;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc;
  logic [W-1:0]    opnd;
  logic [W-1:0]    a_orig;
  logic            b_zero;
  logic            neg_main;
  logic            neg_rem;
  alu_md_fn        fn_q;

  alu_md_fn        start_fn;
  logic            signed_a;
  logic            signed_b;
  logic            neg_a;
  logic            neg_b;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;

  logic [2*W-1:0]  acc_step;
  logic [W:0]      mul_sum;
  logic [W:0]      div_shift;
  logic [W:0]      div_diff;
  logic [2*W-1:0]  prod_fixed;
  logic [W-1:0]    quo;
  logic [W-1:0]    rem;

  assign start_fn = alu_md_fn'(fn);

  // Operand signedness per function; magnitudes are what the iteration uses.
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (start_fn)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      MD_MULHSU: signed_a = 1'b1;
      default: ;
    endcase
    neg_a = signed_a && a[W-1];
    neg_b = signed_b && b[W-1];
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;
  end

  // One iteration. Multiply: shift-add with the multiplier in the low half.
  // Divide: restoring division with the dividend shifting out of the low half
  // and quotient bits shifting in behind it; the high half is the remainder.
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (fn_q[2]) begin
      if (!div_diff[W]) acc_step = {div_diff[W-1:0], acc[W-2:0], 1'b1};
      else              acc_step = {div_shift[W-1:0], acc[W-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[W-1:1]};
    end
  end

  // Sign fix-up applied to the final iteration's value; divide by zero is
  // defined explicitly rather than left to the iteration.
  always_comb begin
    prod_fixed = neg_main ? -acc_step : acc_step;
    quo        = acc_step[W-1:0];
    rem        = acc_step[2*W-1:W];
    case (fn_q)
      MD_MUL:                       result = prod_fixed[W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fixed[2*W-1:W];
      MD_DIV, MD_DIVU:              result = b_zero ? '1 : (neg_main ? -quo : quo);
      MD_REM, MD_REMU:              result = b_zero ? a_orig : (neg_rem ? -rem : rem);
      default:                      result = '0;
    endcase
  end

  assign done = busy && (cnt == CW'(1));

  // Operand capture on start, then WORD_WIDTH iterations counted down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_orig   <= '0;
      b_zero   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      fn_q     <= MD_MUL;
    end else if (flush) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= CW'(W);
      fn_q     <= start_fn;
      a_orig   <= a;
      b_zero   <= (b == '0);
      neg_main <= neg_a ^ neg_b;
      neg_rem  <= neg_a;
      if (fn[2]) begin
        acc  <= {{W{1'b0}}, mag_a};
        opnd <= mag_b;
      end else begin
        acc  <= {{W{1'b0}}, mag_b};
        opnd <= mag_a;
      end
    end else if (busy) begin
      acc <= acc_step;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on input and output.
//   clk, reset          : clock, async active-high reset
//   flush               : synchronous kill of any in-flight or held operation
//   in_valid / in_ready : input handshake carrying a, b, op
//   out_valid/out_ready : output handshake carrying result, signal, error
//   result              : WORD_WIDTH-bit result
//   signal              : zero / overflow (add carry, sub borrow) / negative
//   error               : illegal base-op encoding
// Base ops complete in one cycle; op[4]=1 ops go through muldiv_iter.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int OP_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  input  logic [OP_WIDTH-1:0]   op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] result,
  output alu_signal             signal,
  output logic                  error
);

  localparam int W   = WORD_WIDTH;
  localparam int SHW = $clog2(W);

  alu_state     state;
  alu_state     state_next;

  logic         accept;
  logic         is_md;
  logic         md_start;
  logic         md_done;
  logic [W-1:0] md_result;
  logic         load_base;
  logic         load_md;

  alu_base_fn   base_fn;
  logic         variant;
  logic [SHW-1:0] shamt;
  logic [W:0]   sum_ext;
  logic [W:0]   diff_ext;
  logic [W-1:0] base_res;
  logic         base_ovf;
  logic         base_err;

  assign is_md     = op[4];
  assign in_ready  = !flush && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign md_start  = accept && is_md;
  assign load_base = accept && !is_md;
  assign load_md   = (state == ST_BUSY) && md_done && !flush;
  assign out_valid = (state == ST_DONE);

  assign base_fn  = alu_base_fn'(op[3:1]);
  assign variant  = op[0];
  assign shamt    = b[SHW-1:0];
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  // Single-cycle base datapath; diff_ext[W] is the unsigned borrow of a-b.
  always_comb begin
    base_res = '0;
    base_ovf = 1'b0;
    base_err = 1'b0;
    case (base_fn)
      BASE_ADD: begin
        if (variant) begin
          base_res = diff_ext[W-1:0];
          base_ovf = diff_ext[W];
        end else begin
          base_res = sum_ext[W-1:0];
          base_ovf = sum_ext[W];
        end
      end
      BASE_SLL:  base_res = a << shamt;
      BASE_SLT:  base_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      BASE_SLTU: base_res = {{(W-1){1'b0}}, (a < b)};
      BASE_XOR:  base_res = a ^ b;
      BASE_SHR:  base_res = variant ? W'($signed(a) >>> shamt) : (a >> shamt);
      BASE_OR:   base_res = a | b;
      BASE_AND:  base_res = a & b;
      default:   base_res = '0;
    endcase
    if (!base_op_legal(base_fn, variant)) begin
      base_res = '0;
      base_ovf = 1'b0;
      base_err = 1'b1;
    end
  end

  muldiv_iter #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .start  (md_start),
    .fn     (op[2:0]),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Flush beats everything; a DONE with out_ready can take a new op directly.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_next = is_md ? ST_BUSY : ST_DONE;
        ST_BUSY: if (md_done) state_next = ST_DONE;
        ST_DONE: begin
          if (out_ready) begin
            if (accept) state_next = is_md ? ST_BUSY : ST_DONE;
            else        state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Output registers only change on completion, so they hold through stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      signal <= '0;
      error  <= 1'b0;
    end else if (load_base) begin
      result          <= base_res;
      signal.zero     <= (base_res == '0);
      signal.overflow <= base_ovf;
      signal.negative <= base_res[W-1];
      error           <= base_err;
    end else if (load_md) begin
      result          <= md_result;
      signal.zero     <= (md_result == '0);
      signal.overflow <= 1'b0;
      signal.negative <= md_result[W-1];
      error           <= 1'b0;
    end
  end

endmodule
